mem_burst_master: RTL and testbench
===================================

Name: mem_burst_master

Overview:
- Initiator for the 4 KB byte-wide memory port (write_enable / address / data_in / data_out).
- Accepts burst read or write commands on a valid/ready interface and streams write data in and read data out.
- Sequences the memory pins cycle by cycle.
- Replaces hand-driven address/write_enable stimulus with a reusable engine for loaders, checkers and CPU-side bridges.

Parameters:
ADDR_W, 12, memory address width (4096 locations)
DATA_W, 8, memory data width
LEN_W, 4, burst length field width; a burst is cmd_len+1 beats (1..16)
RD_LAT, 1, memory read latency in cycles from address presented to data_out valid (1..4)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at edge
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_W  start address
cmd_len  input  LEN_W  beats minus one
wr_valid  input  1  write beat available
wr_ready  output  1  write beat accepted when wr_valid & wr_ready at edge
wr_data  input  DATA_W  write beat data
rd_valid  output  1  read beat valid (single-cycle pulse, no backpressure)
rd_data  output  DATA_W  read beat data
rd_last  output  1  high with final rd_valid of a burst
busy  output  1  high whenever state != IDLE
mem_write_enable  output  1  to memory write_enable
mem_address  output  ADDR_W  to memory address
mem_data_in  output  DATA_W  to memory data_in
mem_data_out  input  DATA_W  from memory data_out

Behaviour:
- Reset (rst_n=0 at edge): state IDLE. All outputs 0 except cmd_ready=1. Beat counters and read pipeline cleared. Reset mid-burst aborts immediately; no further mem_write_enable or rd_valid.
- States: IDLE, WRITE, READ, DRAIN.
- Combinational: cmd_ready = (state==IDLE). wr_ready = (state==WRITE).
- IDLE: on cmd_valid accept, latch addr and len, zero beat count, go WRITE if cmd_write else READ.
- Registered: mem_write_enable, mem_address, mem_data_in, rd_valid, rd_data, rd_last.
- WRITE, per beat accepted at edge E:
  - After E: mem_write_enable=1, mem_address=start+beat, mem_data_in=wr_data.
  - Cycle without a beat: mem_write_enable=0, address/data hold.
  - After the last beat: go IDLE. mem_write_enable is still 1 in that first IDLE cycle, so the final write lands one edge later.
- READ:
  - Command accepted at edge E0; beat i address is presented after edge E0+1+i, one per cycle, no gaps.
  - mem_write_enable=0 throughout.
  - Issue pipeline of depth RD_LAT+1 tags each beat and marks the last.
  - Beat i sampled from mem_data_out into rd_data, with rd_valid=1, after edge E0+1+i+RD_LAT+1.
  - RD_LAT=1: first rd_valid is in the 3rd cycle after acceptance.
  - After the last address issues: go DRAIN. DRAIN goes IDLE on the edge that registers the rd_last beat.
- Address arithmetic: start+beat modulo 2^ADDR_W; 4095 wraps to 0.
- Read-after-write: a read accepted in the cycle the final write is presented returns the new data.
- cmd_len=0: single beat. Writes: one mem_write_enable pulse. Reads: rd_valid and rd_last together.
- wr_valid outside WRITE is ignored. cmd_valid while busy is held off (cmd_ready=0).
- mem_data_in is updated only by write beats.

Test Plan:
- Reset then idle → cmd_ready=1, busy=0, mem_write_enable=0, rd_valid=0; assert rst_n=0 mid-burst → outputs cleared on the next edge.
- Write burst, addr 0x000, len 3, data A5,5A,FF,00, wr_valid continuous → 4 consecutive mem_write_enable cycles at addresses 0..3 with matching data; busy drops after the 4th beat.
- Read burst, addr 0x000, len 3, after the above write → rd_valid 4 consecutive cycles with A5,5A,FF,00; rd_last on 00; first rd_valid 3 cycles after acceptance (RD_LAT=1).
- Write, addr 0xFFE, len 3, with wr_valid gaps (valid,0,valid,0,valid,valid) → mem_write_enable low on gap cycles; addresses FFE,FFF,000,001.
- Single-beat write 0x3C to 0x7FF immediately followed by a single-beat read of 0x7FF → rd_data=3C with rd_valid=1 and rd_last=1.
- cmd_valid held during a read burst → cmd_ready=0 until DRAIN completes; queued command accepted in the first IDLE cycle.

Source files
------------

// File: rtl/mem_burst_master.sv
// mem_burst_master: burst read/write engine sequencing a byte-wide synchronous memory port
module mem_burst_master #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
    state_t            state;
    logic [ADDR_W-1:0] start_addr, beat_addr;
    logic [LEN_W-1:0]  len, beat;
    logic [RD_LAT:0]   pipe_v, pipe_l;
    logic              issue, last_beat, drain_done;
    always_comb begin
        cmd_ready  = state == IDLE;
        wr_ready   = state == WRITE;
        busy       = state != IDLE;
        issue      = state == READ;
        last_beat  = beat == len;
        beat_addr  = start_addr + ADDR_W'(beat);
        drain_done = pipe_v[RD_LAT] & pipe_l[RD_LAT];
    end
    // the tag pipeline spans address issue plus RD_LAT so each tag meets its data at mem_data_out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            start_addr       <= '0;
            len              <= '0;
            beat             <= '0;
            pipe_v           <= '0;
            pipe_l           <= '0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_data_in      <= '0;
            rd_valid         <= 1'b0;
            rd_data          <= '0;
            rd_last          <= 1'b0;
        end else begin
            pipe_v           <= {pipe_v[RD_LAT-1:0], issue};
            pipe_l           <= {pipe_l[RD_LAT-1:0], issue & last_beat};
            rd_valid         <= pipe_v[RD_LAT];
            rd_last          <= drain_done;
            mem_write_enable <= 1'b0;
            if (pipe_v[RD_LAT]) rd_data <= mem_data_out;
            case (state)
                IDLE: if (cmd_valid) begin
                    start_addr <= cmd_addr;
                    len        <= cmd_len;
                    beat       <= '0;
                    state      <= cmd_write ? WRITE : READ;
                end
                WRITE: if (wr_valid) begin
                    mem_write_enable <= 1'b1;
                    mem_address      <= beat_addr;
                    mem_data_in      <= wr_data;
                    beat             <= beat + 1'b1;
                    if (last_beat) state <= IDLE;
                end
                READ: begin
                    mem_address <= beat_addr;
                    beat        <= beat + 1'b1;
                    if (last_beat) state <= DRAIN;
                end
                DRAIN: if (drain_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: directed bench with a transaction-level scoreboard of mem_burst_master
module tb_mem_burst_master;
    localparam int AW = 12, DW = 8, LW = 4, RD_LAT = 1;
    logic clk = 0, rst_n = 0, cmd_valid = 0, cmd_write = 0, wr_valid = 0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic cmd_ready, wr_ready, rd_valid, rd_last, busy, mem_write_enable;
    logic [DW-1:0] rd_data, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_address;
    int vectors = 0, errors = 0, cyc = 0;

    mem_burst_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
        .mem_write_enable(mem_write_enable), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    initial forever #5 clk = ~clk;
    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    bit [DW-1:0] mem [1<<AW];
    bit [DW-1:0] dq [RD_LAT];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address] <= mem_data_in;
        dq[0] <= mem[mem_address];
        for (int k = 1; k < RD_LAT; k++) dq[k] <= dq[k-1];
    end
    assign mem_data_out = dq[RD_LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: expectations are keyed by the edge number after which they must be visible
    bit [DW-1:0]   ref_mem [1<<AW];
    logic [AW-1:0] exp_wa[int], exp_ra[int];
    logic [DW-1:0] exp_wd[int], exp_rd[int];
    bit            exp_rl[int];
    int m_mode = 0, m_beat = 0, m_len = 0, m_done = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_mode = 0;
            m_wd = '0;
            exp_wa.delete(); exp_ra.delete(); exp_wd.delete(); exp_rd.delete(); exp_rl.delete();
        end else if (m_mode == 0) begin
            if (cmd_valid) begin
                m_addr = cmd_addr;
                m_len = int'(cmd_len);
                m_beat = 0;
                if (cmd_write) m_mode = 1;
                else begin
                    m_mode = 2;
                    m_done = cyc + m_len + RD_LAT + 2;
                    for (int i = 0; i <= m_len; i++) begin
                        exp_ra[cyc+1+i] = m_addr + AW'(i);
                        exp_rd[cyc+2+RD_LAT+i] = ref_mem[m_addr + AW'(i)];
                        exp_rl[cyc+2+RD_LAT+i] = (i == m_len);
                    end
                end
            end
        end else if (m_mode == 1) begin
            if (wr_valid) begin
                exp_wa[cyc] = m_addr + AW'(m_beat);
                exp_wd[cyc] = wr_data;
                ref_mem[m_addr + AW'(m_beat)] = wr_data;
                m_wd = wr_data;
                m_beat++;
                if (m_beat > m_len) m_mode = 0;
            end
        end else if (cyc == m_done) m_mode = 0;
    end

    typedef struct {int c; logic [AW-1:0] a; logic [DW-1:0] d; logic l;} ent_t;
    ent_t wlog[$], rlog[$];
    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            chk("cmd_ready", cmd_ready, m_mode == 0);
            chk("busy", busy, m_mode != 0);
            chk("wr_ready", wr_ready, m_mode == 1);
            chk("mem_we", mem_write_enable, exp_wa.exists(cyc));
            if (exp_wa.exists(cyc)) chk("wr_addr", mem_address, exp_wa[cyc]);
            if (exp_ra.exists(cyc)) chk("rd_addr", mem_address, exp_ra[cyc]);
            chk("mem_data_in", mem_data_in, m_wd);
            chk("rd_valid", rd_valid, exp_rd.exists(cyc));
            if (exp_rd.exists(cyc)) chk("rd_data", rd_data, exp_rd[cyc]);
            chk("rd_last", rd_last, exp_rl.exists(cyc) && exp_rl[cyc]);
            if (mem_write_enable) wlog.push_back('{cyc, mem_address, mem_data_in, 1'b0});
            if (rd_valid) rlog.push_back('{cyc, mem_address, rd_data, rd_last});
        end
    end

    task automatic do_cmd(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l, output int acc);
        int t = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
        while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
        if (!cmd_ready) chk("cmd_accept_timeout", t, 0);
        @(negedge clk);
        acc = cyc;
        cmd_valid = 0;
    endtask

    logic [DW-1:0] wq[$];
    bit gp[$];
    task automatic feed();
        int idx = 0, k = 0;
        bit acc;
        while (idx < wq.size() && k < 100) begin
            wr_valid = (k < gp.size()) ? gp[k] : 1'b1;
            wr_data = wr_valid ? wq[idx] : ~wq[idx];
            acc = wr_valid & wr_ready;
            @(negedge clk);
            if (acc) idx++;
            k++;
        end
        if (idx < wq.size()) chk("feed_timeout", idx, wq.size());
        wr_valid = 0;
    endtask

    initial begin
        int a1, a2;
        logic [DW-1:0] d4[4];
        logic [AW-1:0] ad4[4];
        int off[4];
        repeat (2) @(negedge clk);
        rst_n = 1;
        wr_valid = 1; wr_data = 8'h77;
        repeat (3) @(negedge clk);
        wr_valid = 0;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_we", mem_write_enable, 0);
        chk("idle_rd_valid", rd_valid, 0);

        wlog.delete();
        do_cmd(1, 12'h000, 4'd3, a1);
        wq = '{8'hA5, 8'h5A, 8'hFF, 8'h00}; gp = '{1, 1, 1, 1};
        feed();
        repeat (3) @(negedge clk);
        d4 = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
        chk("wr0_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            chk("wr0_first_cycle", wlog[0].c - a1, 1);
            for (int i = 0; i < 4; i++) begin
                chk("wr0_addr", wlog[i].a, AW'(i));
                chk("wr0_data", wlog[i].d, d4[i]);
                chk("wr0_consecutive", wlog[i].c - wlog[0].c, i);
            end
        end

        rlog.delete();
        do_cmd(0, 12'h000, 4'd3, a1);
        repeat (8) @(negedge clk);
        chk("rd0_count", rlog.size(), 4);
        if (rlog.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("rd0_data", rlog[i].d, d4[i]);
                chk("rd0_last", rlog[i].l, i == 3);
                chk("rd0_cycle", rlog[i].c - a1, 3 + i);
            end

        wlog.delete();
        do_cmd(1, 12'hFFE, 4'd3, a1);
        wq = '{8'h11, 8'h22, 8'h33, 8'h44}; gp = '{1, 0, 1, 0, 1, 1};
        feed();
        repeat (3) @(negedge clk);
        ad4 = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        off = '{0, 2, 4, 5};
        chk("wr1_count", wlog.size(), 4);
        if (wlog.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("wr1_wrap_addr", wlog[i].a, ad4[i]);
                chk("wr1_gap_cycle", wlog[i].c - wlog[0].c, off[i]);
            end

        rlog.delete();
        do_cmd(1, 12'h7FF, 4'd0, a1);
        wr_valid = 1; wr_data = 8'h3C;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h7FF; cmd_len = 4'd0;
        @(negedge clk);
        wr_valid = 0;
        do_cmd(0, 12'h7FF, 4'd0, a2);
        chk("raw_back_to_back", a2 - a1, 2);
        repeat (6) @(negedge clk);
        chk("raw_count", rlog.size(), 1);
        if (rlog.size() == 1) begin
            chk("raw_data", rlog[0].d, 8'h3C);
            chk("raw_last", rlog[0].l, 1);
        end

        rlog.delete();
        do_cmd(0, 12'h000, 4'd3, a1);
        do_cmd(0, 12'hFFE, 4'd1, a2);
        chk("held_off_accept", a2 - a1, 7);
        repeat (8) @(negedge clk);
        chk("held_count", rlog.size(), 6);
        if (rlog.size() == 6) begin
            chk("held_d0", rlog[0].d, 8'h33);
            chk("held_last0", rlog[3].l, 1);
            chk("held_d5", rlog[5].d, 8'h22);
            chk("held_last5", rlog[5].l, 1);
            chk("held_cycle", rlog[4].c - a2, 3);
        end

        do_cmd(1, 12'h100, 4'd7, a1);
        wr_valid = 1;
        wr_data = 8'hC1; @(negedge clk);
        wr_data = 8'hC2; @(negedge clk);
        wr_data = 8'hC3; @(negedge clk);
        wr_data = 8'hC4; rst_n = 0; @(negedge clk);
        chk("abort_we", mem_write_enable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        rst_n = 1; wr_valid = 0;
        do_cmd(0, 12'h100, 4'd15, a1);
        repeat (4) @(negedge clk);
        rst_n = 0; @(negedge clk);
        chk("abort_rd_valid", rd_valid, 0);
        rst_n = 1;
        rlog.delete();
        repeat (6) @(negedge clk);
        chk("abort_rd_silent", rlog.size(), 0);
        do_cmd(0, 12'h100, 4'd2, a1);
        repeat (6) @(negedge clk);
        chk("abort_readback_count", rlog.size(), 3);
        if (rlog.size() == 3) begin
            chk("abort_readback0", rlog[0].d, 8'hC1);
            chk("abort_readback2", rlog[2].d, 8'hC3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
